// File: rtl/wbwalker_multi.sv
// Wishbone-controlled LED walker with NLEDS outputs.
// Two registers: CTRL (addr 0) starts/aborts a walk and reads back status,
// DIV (addr 1) sets the number of clocks each LED element is held.
// Bus handshake: a request is taken when i_cyc && i_stb && !o_stall; o_ack
// rises exactly one cycle later. Only a start write while a walk is running
// stalls; reads, DIV writes and aborts are always taken.
module wbwalker_multi #(
   parameter int NLEDS       = 8,
   parameter int DEFAULT_DIV = 50_000_000
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_cyc,
   input  logic             i_stb,
   input  logic             i_we,
   input  logic             i_addr,
   input  logic [31:0]      i_data,
   output logic             o_stall,
   output logic             o_ack,
   output logic [31:0]      o_data,
   output logic [NLEDS-1:0] o_led,
   output logic             o_done
);

   localparam logic [7:0] LAST = 8'(NLEDS - 1);

   typedef enum logic {ST_IDLE = 1'b0, ST_WALK = 1'b1} state_t;

   state_t      state, nxt_state;
   logic [1:0]  mode, nxt_mode;
   logic [7:0]  passes, nxt_passes;
   logic [7:0]  pos, nxt_pos;
   logic        dir, nxt_dir;       // bounce only: 1 once heading back down
   logic [31:0] cnt, nxt_cnt;
   logic [31:0] div;
   logic        nxt_done;

   logic        busy, accept, wr_ctrl, wr_div, abort_req, start_req;
   logic        strobe, at_last, is_asc, is_desc;
   logic [31:0] div_m1, status;
   logic        unused_ok;

   assign busy      = (state == ST_WALK);
   assign o_stall   = busy && i_we && !i_addr && !i_data[31];
   assign accept    = i_cyc && i_stb && !o_stall;
   assign wr_ctrl   = accept && i_we && !i_addr;
   assign wr_div    = accept && i_we && i_addr;
   assign abort_req = wr_ctrl && i_data[31];
   assign start_req = wr_ctrl && !i_data[31] && !busy;

   // Mode 3 walks like bounce; only 1 and 2 are sweeps.
   assign is_asc  = (mode == 2'd1);
   assign is_desc = (mode == 2'd2);

   // A DIV of 0 behaves as 1; >= lets a shrunk DIV take effect immediately.
   assign div_m1 = (div == 32'd0) ? 32'd0 : div - 32'd1;
   assign strobe = busy && (cnt >= div_m1);

   // Last element of the current sequence.
   always_comb begin
      if (is_asc)       at_last = (pos == LAST);
      else if (is_desc) at_last = (pos == 8'd0);
      else              at_last = (NLEDS == 1) || (dir && pos == 8'd0);
   end

   assign status = busy ? {1'b1, 5'b0, mode, passes, 8'b0, pos} : 32'd0;

   assign unused_ok = ^{i_data[30:16], i_data[7:2]};

   // Next walk state: abort beats strobe, start only from idle.
   always_comb begin
      nxt_state  = state;
      nxt_mode   = mode;
      nxt_passes = passes;
      nxt_pos    = pos;
      nxt_dir    = dir;
      nxt_cnt    = cnt;
      nxt_done   = 1'b0;
      if (abort_req && busy) begin
         nxt_state  = ST_IDLE;
         nxt_passes = 8'd0;
         nxt_pos    = 8'd0;
         nxt_dir    = 1'b0;
         nxt_cnt    = 32'd0;
      end else if (start_req) begin
         nxt_state  = ST_WALK;
         nxt_mode   = i_data[1:0];
         nxt_passes = (i_data[15:8] == 8'd0) ? 8'd1 : i_data[15:8];
         nxt_pos    = (i_data[1:0] == 2'd2) ? LAST : 8'd0;
         nxt_dir    = 1'b0;
         nxt_cnt    = 32'd0;
      end else if (strobe) begin
         nxt_cnt = 32'd0;
         if (at_last) begin
            if (passes > 8'd1) begin
               nxt_passes = passes - 8'd1;
               nxt_pos    = is_desc ? LAST : 8'd0;
               nxt_dir    = 1'b0;
            end else begin
               nxt_state  = ST_IDLE;
               nxt_passes = 8'd0;
               nxt_pos    = 8'd0;
               nxt_dir    = 1'b0;
               nxt_done   = 1'b1;
            end
         end else if (is_asc) begin
            nxt_pos = pos + 8'd1;
         end else if (is_desc) begin
            nxt_pos = pos - 8'd1;
         end else if (!dir && pos == LAST) begin
            nxt_dir = 1'b1;
            nxt_pos = pos - 8'd1;
         end else if (!dir) begin
            nxt_pos = pos + 8'd1;
         end else begin
            nxt_pos = pos - 8'd1;
         end
      end else if (busy) begin
         nxt_cnt = cnt + 32'd1;
      end
   end

   // Register walk state, bus responses and the LED/done outputs.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state  <= ST_IDLE;
         mode   <= 2'd0;
         passes <= 8'd0;
         pos    <= 8'd0;
         dir    <= 1'b0;
         cnt    <= 32'd0;
         div    <= 32'(DEFAULT_DIV);
         o_ack  <= 1'b0;
         o_data <= 32'd0;
         o_led  <= '0;
         o_done <= 1'b0;
      end else begin
         state  <= nxt_state;
         mode   <= nxt_mode;
         passes <= nxt_passes;
         pos    <= nxt_pos;
         dir    <= nxt_dir;
         cnt    <= nxt_cnt;
         o_done <= nxt_done;
         o_ack  <= accept;
         o_led  <= (nxt_state == ST_WALK) ? (NLEDS'(1) << nxt_pos) : '0;
         if (wr_div)
            div <= i_data;
         if (accept)
            o_data <= i_we ? 32'd0 : (i_addr ? div : status);
      end
   end

endmodule
